// File: rtl/fetch_entry_queue.sv
// fetch_entry_queue: frontend-to-id_stage FIFO with flush/clear; define FETCH_QUEUE_BYPASS_EN for empty-queue bypass.
module fetch_entry_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 64
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clr_i,
  input  logic                       flush_i,
  input  logic [WIDTH-1:0]           fetch_entry_i,
  input  logic                       fetch_entry_valid_i,
  output logic                       fetch_entry_ready_o,
  output logic [WIDTH-1:0]           fetch_entry_o,
  output logic                       fetch_entry_valid_o,
  input  logic                       fetch_entry_ready_i,
  output logic [$clog2(DEPTH):0]     usage_o
);
  localparam int unsigned AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rptr, r_wptr;
  logic [AW:0]      r_cnt;
  logic             w_empty, w_push, w_pop, w_byp;
  assign w_empty             = (r_cnt == '0);
  assign fetch_entry_ready_o = (r_cnt != (AW+1)'(DEPTH));
  assign usage_o             = r_cnt;
`ifdef FETCH_QUEUE_BYPASS_EN
  // an empty queue forwards the incoming entry; it is only stored if id_stage stalls
  assign w_byp               = w_empty & fetch_entry_ready_i;
  assign fetch_entry_valid_o = w_empty ? (fetch_entry_valid_i & ~flush_i) : 1'b1;
  assign fetch_entry_o       = w_empty ? fetch_entry_i : r_mem[r_rptr];
`else
  assign w_byp               = 1'b0;
  assign fetch_entry_valid_o = ~w_empty;
  assign fetch_entry_o       = r_mem[r_rptr];
`endif
  assign w_push = fetch_entry_valid_i & fetch_entry_ready_o & ~flush_i & ~w_byp;
  assign w_pop  = fetch_entry_valid_o & fetch_entry_ready_i & ~w_empty;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i || clr_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush_i) begin
      r_rptr <= '0;
      r_wptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_mem[r_wptr] <= fetch_entry_i;
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop) r_rptr <= r_rptr + AW'(1);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: tb/tb_fetch_entry_queue.sv
// tb_fetch_entry_queue: randomized scoreboard bench for fetch_entry_queue against a queue-based model.
module tb_fetch_entry_queue;
  localparam int DEPTH = 4;
  localparam int W = 32;
  logic clk = 0, rst_i = 0, clr_i = 0, flush_i = 0, vi = 0, ri = 0;
  logic [W-1:0] di = '0;
  logic [W-1:0] dout;
  logic vo, ro;
  logic [$clog2(DEPTH):0] usage;
  int checks = 0, errors = 0;
  logic [W-1:0] exp_q [$];
  bit pushed_now = 0;

  fetch_entry_queue #(.DEPTH(DEPTH), .WIDTH(W)) dut (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .flush_i(flush_i),
    .fetch_entry_i(di), .fetch_entry_valid_i(vi), .fetch_entry_ready_o(ro),
    .fetch_entry_o(dout), .fetch_entry_valid_o(vo), .fetch_entry_ready_i(ri),
    .usage_o(usage)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [W-1:0] act, logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // stimulus side: the model accepts an entry whenever it holds fewer than DEPTH
  task automatic step(bit v, logic [W-1:0] d, bit r, bit fl = 0, bit cl = 0);
    @(posedge clk);
    #1;
    vi = v; di = d; ri = r; flush_i = fl; clr_i = cl; pushed_now = 0;
    if (v && !fl && !cl && exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      pushed_now = 1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    vi = 0; ri = 0; flush_i = 0; clr_i = 0; di = '0; pushed_now = 0;
    #2 rst_i = 1;
    #1;
    chk("rst_valid", W'(vo), W'(0));
    chk("rst_ready", W'(ro), W'(1));
    chk("rst_usage", W'(usage), W'(0));
    chk("rst_head", dout, '0);
    repeat (2) @(posedge clk);
    #3 rst_i = 0;
  endtask

  // monitor: compares outputs against the model and retires entries id_stage takes
  always @(negedge clk) begin
    int n;
    bit ev;
    logic [W-1:0] eh;
    n = exp_q.size() - int'(pushed_now);
    ev = (n != 0);
    eh = (n != 0) ? exp_q[0] : '0;
`ifdef FETCH_QUEUE_BYPASS_EN
    ev = ev || (vi && !flush_i);
    if (n == 0) eh = di;
`endif
    if (!rst_i) begin
      chk("usage", W'(usage), W'(n));
      chk("ready", W'(ro), W'(n != DEPTH));
      chk("valid", W'(vo), W'(ev));
      if (ev) chk("head", dout, eh);
      if (ev && ri && exp_q.size() > 0) void'(exp_q.pop_front());
    end
    if (rst_i || clr_i || flush_i) exp_q.delete();
    pushed_now = 0;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 32'hA0 + i, 0);
    step(0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 32'hB0 + i, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'hC0 + i, 0);
    step(1, 32'hEE, 0, 1);
    step(0, 0, 1);
    step(1, 32'hD0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 32'hE0 + i, 0);
    step(1, 32'hFF, 1);
    step(0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 32'h1F0 + i, 0);
    step(0, 0, 0, 0, 1);
    step(1, 32'hF1, 1);
    step(1, 32'hF2, 0);
    step(0, 0, 1);
    for (int i = 0; i < 3; i++) step(1, 32'h200 + i, 0);
    do_reset();
    for (int blk = 0; blk < 15; blk++) begin
      int rb, vb;
      rb = $urandom_range(1, 9);
      vb = $urandom_range(1, 9);
      for (int i = 0; i < 200; i++)
        step($urandom_range(0, 9) < vb, $urandom, $urandom_range(0, 9) < rb,
             $urandom_range(0, 39) == 0, $urandom_range(0, 79) == 0);
      if (blk % 5 == 4) do_reset();
    end
    step(0, 0, 1);
    step(0, 0, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
